// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-path definitions: idle instruction, fetch exception codes, sequencer states.
package cpu_fetch_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [3:0]  EXC_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0]  EXC_INSTR_ACCESS     = 4'd1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational alignment and bounds check of a byte address against a word-addressed memory.
module fetch_addr_check #(
  parameter int unsigned MEM_WORDS = 2048
) (
  input  logic [63:0] pc,
  output logic        fault,
  output logic [3:0]  code
);
  import cpu_fetch_pkg::*;

  logic misaligned;
  logic oob;

  assign misaligned = (pc[1:0] != 2'b00);
  // Full 62-bit word index compare so high address bits can never alias into range.
  assign oob        = (pc[63:2] >= 62'(MEM_WORDS));
  assign fault      = misaligned | oob;
  assign code       = misaligned ? EXC_INSTR_MISALIGNED : EXC_INSTR_ACCESS;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads a combinational imem and issues one
// registered packet per cycle to decode; faults are reported once, then it halts until redirect.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
  parameter int unsigned MEM_WORDS = 2048,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_exc_en,
  output logic [3:0]  if_exc_code,
  output logic [63:0] if_exc_val
);
  import cpu_fetch_pkg::*;

  fetch_state_e state_q;
  logic [63:0]  pc_q;
  logic [63:0]  pc_d;
  logic         valid_q;
  logic [63:0]  ipc_q;
  logic [31:0]  instr_q;
  logic         exc_en_q;
  logic [3:0]   exc_code_q;
  logic [63:0]  exc_val_q;

  logic         slot_free;
  logic         fault;
  logic [3:0]   fault_code;

  fetch_addr_check #(
    .MEM_WORDS(MEM_WORDS)
  ) u_addr_check (
    .pc   (pc_q),
    .fault(fault),
    .code (fault_code)
  );

  assign slot_free = !valid_q || if_ready;
  assign pc_d      = pc_q + 64'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      ipc_q      <= 64'd0;
      instr_q    <= NOP_INSTR;
      exc_en_q   <= 1'b0;
      exc_code_q <= 4'd0;
      exc_val_q  <= 64'd0;
    end else if (redirect_en) begin
      // Redirect wins over stall and handshake: any pending packet is dropped.
      state_q <= RUN;
      pc_q    <= redirect_pc;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (slot_free) begin
            valid_q <= 1'b1;
            ipc_q   <= pc_q;
            if (fault) begin
              state_q    <= HALT;
              instr_q    <= NOP_INSTR;
              exc_en_q   <= 1'b1;
              exc_code_q <= fault_code;
              exc_val_q  <= pc_q;
            end else begin
              pc_q       <= pc_d;
              instr_q    <= imem_rdata;
              exc_en_q   <= 1'b0;
              exc_code_q <= 4'd0;
              exc_val_q  <= 64'd0;
            end
          end
        end
        HALT: begin
          if (valid_q && if_ready) valid_q <= 1'b0;
        end
        default: state_q <= HALT;
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = valid_q;
  assign if_pc       = ipc_q;
  assign if_instr    = instr_q;
  assign if_exc_en   = exc_en_q;
  assign if_exc_code = exc_code_q;
  assign if_exc_val  = exc_val_q;

endmodule
